// File: rtl/multiplication_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package multiplication_pkg;

    // Default operand width. The product is twice this wide.
    localparam int DEFAULT_WIDTH = 4;

    // Two-state controller encoding. It is kept as plain logic constants so
    // that legacy tools which do not understand enums can use it.
    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/multiplication_unit.sv
// Unsigned sequential shift-add multiplier. It takes WIDTH x WIDTH operands and
// returns a 2*WIDTH-bit product after exactly WIDTH iterations. Operands of zero
// get no early exit, so the latency is always the same.
module multiplication_unit
    import multiplication_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_r;
    logic [PW-1:0]      mcand_r;    // multiplicand, shifted left one place each iteration
    logic [WIDTH-1:0]   mplier_r;   // multiplier, shifted right so bit 0 is the current digit
    logic [PW-1:0]      acc_r;      // running partial-product sum
    logic [CNT_W-1:0]   cnt_r;      // number of iterations still to run
    logic [PW-1:0]      product_r;
    logic               busy_r;
    logic               done_r;

    logic [PW-1:0]      addend_s;
    logic [PW-1:0]      acc_next_s;
    logic               last_iter_s;

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        addend_s    = {PW{1'b0}};
        acc_next_s  = {PW{1'b0}};
        last_iter_s = 1'b0;
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {PW{1'b0}};
        end
        acc_next_s = acc_r + addend_s;
        if (cnt_r == CNT_W'(1)) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
    end

    // Controller and datapath registers. The result is committed on the final iteration edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {PW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {PW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, A};
                        mplier_r <= B;
                        acc_r    <= {PW{1'b0}};
                        cnt_r    <= CNT_W'(WIDTH);
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r - CNT_W'(1);
                    if (last_iter_s) begin
                        product_r <= acc_next_s;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign Product = product_r;

endmodule

// File: tb/tb_multiplication_unit.sv
// Scoreboard bench for multiplication_unit. A cycle-level reference model pushes
// expected products and completion cycles. A separate monitor checks every cycle.
module tb_multiplication_unit;

    localparam int W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   Product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_cyc;
    } exp_t;

    exp_t           q[$];
    int             cyc;
    int             free_at;
    logic [2*W-1:0] held;
    int             checks;
    int             errors;

    multiplication_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a request is accepted when the unit is free, and the result is the plain product.
    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            free_at = cyc + 1;
        end else if (start === 1'b1 && cyc >= free_at) begin
            exp_t e;
            e.prod     = (2*W)'(A) * (2*W)'(B);
            e.done_cyc = cyc + W + 1;
            q.push_back(e);
            free_at    = cyc + W + 1;
        end
        cyc = cyc + 1;
    end

    // Reset discards any operation in flight and clears the visible result.
    always @(negedge rst_n) begin
        q.delete();
        held = '0;
    end

    // Monitor: compare the DUT outputs with the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("done_busy_overlap", {31'd0, done & busy}, 32'd0);
            if (q.size() > 0 && cyc > q[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_done: got no done expected done at cycle %0d", q[0].done_cyc);
                void'(q.pop_front());
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", 32'(Product), 32'(e.prod));
                    chk("done_latency", cyc, e.done_cyc);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    held = e.prod;
                end
            end else begin
                chk("product_hold", 32'(Product), 32'(held));
                chk("busy", {31'd0, busy},
                    {31'd0, (q.size() > 0 && cyc < q[0].done_cyc)});
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk); #2;
        start = 1'b1; A = a; B = b;
        @(negedge clk); #2;
        start = 1'b0;
        repeat (W) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] da [5];
        logic [W-1:0] db [5];
        cyc = 0; free_at = 0; held = '0; checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_product", 32'(Product), 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed sequence
        da = '{4'd3, 4'd5, 4'd15, 4'd9, 4'd6};
        db = '{4'd2, 4'd3, 4'd1, 4'd2, 4'd6};
        for (int i = 0; i < 5; i++) do_op(da[i], db[i]);

        // Corners
        do_op(4'd0, 4'd13);
        do_op(4'd15, 4'd15);
        do_op(4'd1, 4'd1);
        repeat (3) @(negedge clk);

        // Start pulses and operand changes while running are ignored
        @(negedge clk); #2;
        start = 1'b1; A = 4'd7; B = 4'd11;
        @(negedge clk); #2;
        start = 1'b0; A = 4'd2; B = 4'd3;
        @(negedge clk); #2;
        start = 1'b1; A = 4'd15; B = 4'd14;
        @(negedge clk); #2;
        start = 1'b0; A = 4'd9;
        repeat (W + 2) @(negedge clk);

        // Start held high for three back-to-back operations
        @(negedge clk); #2;
        start = 1'b1;
        for (int i = 0; i < 3 * (W + 1); i++) begin
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk); #2;
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Reset during the second iteration
        @(negedge clk); #2;
        start = 1'b1; A = 4'd13; B = 4'd11;
        @(negedge clk); #2;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset_product", 32'(Product), 32'd0);
        chk("midrun_reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_op(4'd12, 4'd10);

        // Exhaustive sweep
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_op(W'(a), W'(b));
            end
        end

        // Random traffic with random start pulses and gaps
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            start = 1'b1;
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk); #2;
            start = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 7)); g++) begin
                start = ($urandom_range(0, 3) == 0);
                A = W'($urandom);
                B = W'($urandom);
                @(negedge clk); #2;
            end
            start = 1'b0;
        end

        // Drain
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplication_unit.md
# multiplication_unit

Unsigned sequential shift-add multiplier: accepts two WIDTH-bit operands on a start pulse and produces the full 2·WIDTH-bit product after WIDTH clock cycles. It is a small arithmetic building block for datapaths that can tolerate multi-cycle latency in exchange for one adder instead of a full array. Default configuration is 4×4 → 8 bits.

## Interface
- WIDTH, 4: operand width in bits; must be ≥ 2.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled only when idle.
- A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
- B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when Product holds a new result.
- Product  output  2·WIDTH  unsigned A×B of the most recently completed operation.

## Operation
- States: IDLE, RUN.
- IDLE: busy=0. On a rising edge with start=1: latch A into multiplicand register (zero-extended to 2·WIDTH), B into multiplier shift register, clear accumulator, load iteration counter with WIDTH, go to RUN.
- RUN: busy=1. Each edge: if multiplier LSB=1, accumulator += multiplicand; multiplicand shifts left 1, multiplier shifts right 1, counter decrements. After the WIDTH-th iteration: copy final accumulator to Product, pulse done, return to IDLE.
- Arithmetic: unsigned only; accumulator is 2·WIDTH bits and never overflows (max (2^WIDTH−1)^2).
- Product is registered and holds its value until the next completion; it is not updated during RUN.
- start while busy=1 is ignored (no queuing); A/B changes during RUN have no effect.
- start may be held high continuously: a new operation is accepted on the first IDLE edge after each completion.
- Operands of zero still take the full WIDTH iterations (no early termination), giving fixed latency.

## Timing
- Reset (rst_n=0, asynchronous assert, synchronous-edge deassert): state=IDLE, busy=0, done=0, Product=0, all internal registers 0.
- Reset asserted mid-RUN aborts the operation immediately; no done pulse; Product returns to 0.
- Accepting edge = edge E (start=1 in IDLE). busy is high from after E until after edge E+WIDTH.
- Result: Product valid and done=1 in the cycle after edge E+WIDTH; done deasserts at edge E+WIDTH+1.
- Latency start-accept to done: WIDTH cycles. Throughput: one result per WIDTH+1 cycles when start is held high (IDLE cycle between operations, in which done=1 and start is accepted).
- done and busy are never high in the same cycle.

## Structure
- Shared package multiplication_pkg: state typedef (IDLE, RUN), default WIDTH constant.
- Single module; datapath (accumulator, shift registers, counter of clog2(WIDTH+1) bits) and two-state control coexist; no sub-module required.
- All outputs driven directly from registers (no combinational paths from inputs to outputs).

## Test plan
- Reset: hold rst_n=0 for 2 cycles → Product=0, busy=0, done=0; release, no activity without start.
- Directed WIDTH=4 sequence: 3×2, 5×3, 15×1, 9×2, 6×6 → Product 6, 15, 15, 18, 36 (00000110, 00001111, 00001111, 00010010, 00100100), each with done exactly 4 cycles after acceptance.
- Corners: 0×13 → 0; 15×15 → 225 (11100001); 1×1 → 1; Product unchanged between completions.
- Ignored start / operand change: pulse start and change A/B mid-RUN → result equals the originally latched operands, single done pulse.
- Back-to-back: start held high for three operations → done pulses every 5 cycles with correct products.
- Reset mid-RUN at iteration 2 → busy=0, Product=0 immediately, no done; next start completes correctly; exhaustive 256-pair sweep matches A×B.
